// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - funct3 encodings for loads/stores
//   - ex_control bit positions used by the stage
//   - FSM state type and access-size type
//   - f3_size(): maps funct3 to an access size (undefined codes become word)
package mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int CTRL_REGWR   = 5;
  localparam int CTRL_MEM2REG = 3;
  localparam int CTRL_MEMWR   = 1;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // Store encodings share the low bits with loads (SB=000, SH=001, SW=010),
  // so one decode serves both. 011/110/111 are undefined and treated as word.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: f3_size = SZ_BYTE;
      F3_LH, F3_LHU: f3_size = SZ_HALF;
      F3_LW:         f3_size = SZ_WORD;
      default:       f3_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data aligner.
// Picks the byte/halfword lane addressed by lane[1:0] out of the read word
// and sign- or zero-extends it according to funct3[2].
// Ports:
//   rdata  [31:0] in  : word returned by data memory
//   lane   [1:0]  in  : low address bits of the access
//   funct3 [2:0]  in  : load size/sign encoding
//   data   [31:0] out : aligned, extended load result
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        uns;

  always_comb begin
    byte_v = rdata[{lane, 3'b000} +: 8];
    // Halfword lane ignores addr[0]; a misaligned half reads the aligned half.
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
    uns    = funct3[2];
    case (f3_size(funct3))
      SZ_BYTE: data = {{24{byte_v[7] & ~uns}}, byte_v};
      SZ_HALF: data = {{16{half_v[15] & ~uns}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory loads/stores from the EX/MEM entry,
// waits for dmem_ack (bounded by WAIT_MAX cycles) and registers the result
// toward write-back. Non-memory entries pass through with one cycle latency.
// Optional build macro: MEM_MISALIGN_CHECK_EN rejects misaligned half/word
// accesses in IDLE with a mem_fault pulse instead of issuing them.
// Ports:
//   clk, rst_n (sync, active-low)
//   ex_valid/ex_ready handshake; ex_alu_result, ex_store_data, ex_funct3,
//   ex_control, ex_rd : EX/MEM entry
//   dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be : memory request (held)
//   dmem_ack, dmem_rdata : memory response
//   wb_regdata, wb_memdata, wb_control, wb_reg_addr : registered WB outputs
//   mem_stall : access outstanding; mem_fault : one-cycle abandon/reject pulse
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  input  logic [7:0]  ex_control,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_regdata,
  output logic [31:0] wb_memdata,
  output logic [7:0]  wb_control,
  output logic [4:0]  wb_reg_addr,
  output logic        mem_stall,
  output logic        mem_fault
);

  // Counter runs 0..WAIT_MAX-1; the last value is the final cycle an ack may win.
  localparam int             CW       = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WAIT_MAX - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   lat_result_q, lat_result_d;
  logic [7:0]    lat_control_q, lat_control_d;
  logic [4:0]    lat_rd_q, lat_rd_d;
  logic [2:0]    lat_funct3_q, lat_funct3_d;
  logic [31:0]   wb_regdata_q, wb_regdata_d;
  logic [31:0]   wb_memdata_q, wb_memdata_d;
  logic [7:0]    wb_control_q, wb_control_d;
  logic [4:0]    wb_reg_addr_q, wb_reg_addr_d;
  logic          dmem_req_q, dmem_req_d;
  logic          dmem_we_q, dmem_we_d;
  logic [31:0]   dmem_addr_q, dmem_addr_d;
  logic [31:0]   dmem_wdata_q, dmem_wdata_d;
  logic [3:0]    dmem_be_q, dmem_be_d;
  logic          mem_fault_q, mem_fault_d;

  size_e         ex_size;
  logic          is_store, is_mem, misalign;
  logic [3:0]    be_v;
  logic [31:0]   wdata_v;
  logic [31:0]   load_data;

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .lane   (lat_result_q[1:0]),
    .funct3 (lat_funct3_q),
    .data   (load_data)
  );

  // Entry decode: size, byte enables and lane-replicated store data.
  always_comb begin
    ex_size  = f3_size(ex_funct3);
    is_store = ex_control[CTRL_MEMWR];
    is_mem   = ex_control[CTRL_MEM2REG] | is_store;
    case (ex_size)
      SZ_BYTE: begin
        be_v    = 4'b0001 << ex_alu_result[1:0];
        wdata_v = {4{ex_store_data[7:0]}};
      end
      SZ_HALF: begin
        be_v    = 4'b0011 << {ex_alu_result[1], 1'b0};
        wdata_v = {2{ex_store_data[15:0]}};
      end
      default: begin
        be_v    = 4'b1111;
        wdata_v = ex_store_data;
      end
    endcase
`ifdef MEM_MISALIGN_CHECK_EN
    case (ex_size)
      SZ_HALF: misalign = ex_alu_result[0];
      SZ_WORD: misalign = |ex_alu_result[1:0];
      default: misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lat_result_d  = lat_result_q;
    lat_control_d = lat_control_q;
    lat_rd_d      = lat_rd_q;
    lat_funct3_d  = lat_funct3_q;
    wb_regdata_d  = wb_regdata_q;
    wb_memdata_d  = wb_memdata_q;
    wb_control_d  = 8'h00;          // bubble unless a result retires this cycle
    wb_reg_addr_d = wb_reg_addr_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    dmem_be_d     = dmem_be_q;
    mem_fault_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            wb_regdata_d  = ex_alu_result;
            wb_memdata_d  = 32'h0;
            wb_control_d  = ex_control;
            wb_reg_addr_d = ex_rd;
          end else if (misalign) begin
            mem_fault_d = 1'b1;
          end else begin
            lat_result_d  = ex_alu_result;
            lat_control_d = ex_control;
            lat_rd_d      = ex_rd;
            lat_funct3_d  = ex_funct3;
            dmem_req_d    = 1'b1;
            dmem_we_d     = is_store;
            dmem_addr_d   = {ex_alu_result[31:2], 2'b00};
            dmem_wdata_d  = wdata_v;
            dmem_be_d     = be_v;
            cnt_d         = '0;
            state_d       = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // Ack is checked first so an ack on the last allowed cycle completes.
        if (dmem_ack) begin
          wb_regdata_d  = lat_result_q;
          wb_memdata_d  = lat_control_q[CTRL_MEMWR] ? 32'h0 : load_data;
          wb_control_d  = lat_control_q;
          if (lat_control_q[CTRL_MEMWR]) wb_control_d[CTRL_REGWR] = 1'b0;
          wb_reg_addr_d = lat_rd_q;
          dmem_req_d    = 1'b0;
          dmem_we_d     = 1'b0;
          state_d       = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          dmem_req_d  = 1'b0;
          dmem_we_d   = 1'b0;
          mem_fault_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      lat_result_q  <= '0;
      lat_control_q <= '0;
      lat_rd_q      <= '0;
      lat_funct3_q  <= '0;
      wb_regdata_q  <= '0;
      wb_memdata_q  <= '0;
      wb_control_q  <= '0;
      wb_reg_addr_q <= '0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      dmem_be_q     <= '0;
      mem_fault_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lat_result_q  <= lat_result_d;
      lat_control_q <= lat_control_d;
      lat_rd_q      <= lat_rd_d;
      lat_funct3_q  <= lat_funct3_d;
      wb_regdata_q  <= wb_regdata_d;
      wb_memdata_q  <= wb_memdata_d;
      wb_control_q  <= wb_control_d;
      wb_reg_addr_q <= wb_reg_addr_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      dmem_be_q     <= dmem_be_d;
      mem_fault_q   <= mem_fault_d;
    end
  end

  assign ex_ready    = (state_q == ST_IDLE);
  assign mem_stall   = (state_q == ST_ACCESS);
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign dmem_be     = dmem_be_q;
  assign wb_regdata  = wb_regdata_q;
  assign wb_memdata  = wb_memdata_q;
  assign wb_control  = wb_control_q;
  assign wb_reg_addr = wb_reg_addr_q;
  assign mem_fault   = mem_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: write-back results are predicted into a
// queue when each entry is driven and popped by a monitor when wb_control
// shows a retiring result.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_funct3;
  logic [7:0]  ex_control;
  logic [4:0]  ex_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_regdata;
  logic [31:0] wb_memdata;
  logic [7:0]  wb_control;
  logic [4:0]  wb_reg_addr;
  logic        mem_stall;
  logic        mem_fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] regdata;
    logic [31:0] memdata;
    logic [7:0]  control;
    logic [4:0]  reg_addr;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] sd;
    logic [2:0]  f3;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    int          delay;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_mem;
    logic [7:0]  exp_ctrl;
  } acc_t;

  wb_t  exp_q[$];
  acc_t ops[$];
  wb_t  mon_e;

  localparam logic [31:0] RDATA = 32'h80FF_1234;

  mem_access_stage #(.WAIT_MAX(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_funct3     (ex_funct3),
    .ex_control    (ex_control),
    .ex_rd         (ex_rd),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_regdata    (wb_regdata),
    .wb_memdata    (wb_memdata),
    .wb_control    (wb_control),
    .wb_reg_addr   (wb_reg_addr),
    .mem_stall     (mem_stall),
    .mem_fault     (mem_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Scoreboard monitor: every non-bubble wb cycle must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_control !== 8'h00) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got ctrl=%h regdata=%h rd=%0d, required no result",
                 wb_control, wb_regdata, wb_reg_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (wb_regdata !== mon_e.regdata || wb_memdata !== mon_e.memdata ||
            wb_control !== mon_e.control || wb_reg_addr !== mon_e.reg_addr) begin
          bad++;
          $display("FAIL wb_result: got reg=%h mem=%h ctrl=%h rd=%0d, required reg=%h mem=%h ctrl=%h rd=%0d",
                   wb_regdata, wb_memdata, wb_control, wb_reg_addr,
                   mon_e.regdata, mon_e.memdata, mon_e.control, mon_e.reg_addr);
        end
      end
    end
  end

  function void add_op(input logic [31:0] addr, input logic [31:0] sd, input logic [2:0] f3,
                       input logic [7:0] ctrl, input logic [4:0] rd, input int delay,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_mem,
                       input logic [7:0] exp_ctrl);
    acc_t a;
    a.addr = addr; a.sd = sd; a.f3 = f3; a.ctrl = ctrl; a.rd = rd; a.delay = delay;
    a.exp_addr = exp_addr; a.exp_be = exp_be; a.exp_wdata = exp_wdata;
    a.exp_mem = exp_mem; a.exp_ctrl = exp_ctrl;
    ops.push_back(a);
  endfunction

  task automatic drive_entry(input logic [31:0] addr, input logic [31:0] sd, input logic [2:0] f3,
                             input logic [7:0] ctrl, input logic [4:0] rd);
    ex_alu_result = addr;
    ex_store_data = sd;
    ex_funct3     = f3;
    ex_control    = ctrl;
    ex_rd         = rd;
    ex_valid      = 1'b1;
    @(posedge clk); #1;
    ex_valid      = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ex_valid = 1'b1; ex_alu_result = 32'h100; ex_store_data = 32'h1;
    ex_funct3 = 3'b010; ex_control = 8'h28; ex_rd = 5'd1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !== 70'h0) begin
      bad++;
      $display("FAIL reset_dmem: got req=%b we=%b addr=%h wdata=%h be=%b, required all 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be);
    end
    total++;
    if ({wb_regdata, wb_memdata, wb_control, wb_reg_addr} !== 77'h0) begin
      bad++;
      $display("FAIL reset_wb: got reg=%h mem=%h ctrl=%h rd=%0d, required all 0",
               wb_regdata, wb_memdata, wb_control, wb_reg_addr);
    end
    total++;
    if (mem_fault !== 1'b0 || mem_stall !== 1'b0 || ex_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ctrl: got fault=%b stall=%b ready=%b, required 0 0 1",
               mem_fault, mem_stall, ex_ready);
    end
    ex_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu;
    exp_q.push_back('{32'h55, 32'h0, 8'h20, 5'd7});
    drive_entry(32'h55, 32'h0, 3'b000, 8'h20, 5'd7);
    total++;
    if (wb_regdata !== 32'h55 || wb_reg_addr !== 5'd7 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      bad++;
      $display("FAIL alu_pass: got reg=%h rd=%0d req=%b stall=%b, required reg=55 rd=7 req=0 stall=0",
               wb_regdata, wb_reg_addr, dmem_req, mem_stall);
    end
    @(posedge clk); #1;
    total++;
    if (wb_control !== 8'h00 || dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL alu_bubble: got ctrl=%h req=%b, required ctrl=00 req=0", wb_control, dmem_req);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3];
    logic [7:0]  ctls [3];
    int          req_seen;
    vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003;
    ctls[0] = 8'h21; ctls[1] = 8'hE4; ctls[2] = 8'h80;
    req_seen = 0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{vals[i], 32'h0, ctls[i], 5'(20 + i)});
      ex_alu_result = vals[i]; ex_store_data = 32'h0; ex_funct3 = 3'b000;
      ex_control = ctls[i]; ex_rd = 5'(20 + i); ex_valid = 1'b1;
      @(posedge clk); #1;
      if (dmem_req !== 1'b0 || ex_ready !== 1'b1) req_seen++;
    end
    ex_valid = 1'b0;
    total++;
    if (req_seen != 0) begin
      bad++;
      $display("FAIL b2b_noreq: got %0d cycles with req/not-ready, required 0", req_seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mem_ops;
    acc_t o;
    int   stall;
    int   unstable;
    add_op(32'h103, 32'h0, 3'b000, 8'h28, 5'd1, 2, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80, 8'h28);
    add_op(32'h102, 32'h0, 3'b100, 8'h28, 5'd2, 0, 32'h100, 4'b0100, 32'h0, 32'h0000_00FF, 8'h28);
    add_op(32'h102, 32'h0, 3'b001, 8'h29, 5'd3, 1, 32'h100, 4'b1100, 32'h0, 32'hFFFF_80FF, 8'h29);
    add_op(32'h106, 32'h0, 3'b101, 8'h28, 5'd4, 0, 32'h104, 4'b1100, 32'h0, 32'h0000_80FF, 8'h28);
    add_op(32'h108, 32'h0, 3'b010, 8'h28, 5'd5, 3, 32'h108, 4'b1111, 32'h0, 32'h80FF_1234, 8'h28);
    add_op(32'h101, 32'h0, 3'b000, 8'h28, 5'd6, 0, 32'h100, 4'b0010, 32'h0, 32'h0000_0012, 8'h28);
    add_op(32'h10C, 32'h0, 3'b011, 8'h28, 5'd8, 0, 32'h10C, 4'b1111, 32'h0, 32'h80FF_1234, 8'h28);
    // Ack on the 15th wait cycle: the last one before the timeout would fire.
    add_op(32'h110, 32'h0, 3'b010, 8'h28, 5'd10, 14, 32'h110, 4'b1111, 32'h0, 32'h80FF_1234, 8'h28);
    add_op(32'h202, 32'h0000_ABCD, 3'b001, 8'h22, 5'd11, 1, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0, 8'h02);
    add_op(32'h301, 32'h0000_00EF, 3'b000, 8'h22, 5'd12, 0, 32'h300, 4'b0010, 32'hEFEF_EFEF, 32'h0, 8'h02);
    add_op(32'h304, 32'hDEAD_BEEF, 3'b010, 8'hA6, 5'd13, 2, 32'h304, 4'b1111, 32'hDEAD_BEEF, 32'h0, 8'h86);
    add_op(32'h308, 32'h1234_5678, 3'b111, 8'h22, 5'd14, 0, 32'h308, 4'b1111, 32'h1234_5678, 32'h0, 8'h02);
`ifndef MEM_MISALIGN_CHECK_EN
    add_op(32'h101, 32'h0, 3'b010, 8'h28, 5'd15, 0, 32'h100, 4'b1111, 32'h0, 32'h80FF_1234, 8'h28);
`endif
    while (ops.size() != 0) begin
      o = ops.pop_front();
      exp_q.push_back('{o.addr, o.exp_mem, o.exp_ctrl, o.rd});
      drive_entry(o.addr, o.sd, o.f3, o.ctrl, o.rd);
      total++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
          {1'b1, o.ctrl[1], o.exp_addr, o.exp_be, o.exp_wdata}) begin
        bad++;
        $display("FAIL mem_req@%h: got req=%b we=%b addr=%h be=%b wdata=%h, required req=1 we=%b addr=%h be=%b wdata=%h",
                 o.addr, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                 o.ctrl[1], o.exp_addr, o.exp_be, o.exp_wdata);
      end
      stall    = (mem_stall === 1'b1) ? 1 : 0;
      unstable = 0;
      for (int i = 0; i < o.delay; i++) begin
        @(posedge clk); #1;
        if (mem_stall === 1'b1) stall++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
            {1'b1, o.ctrl[1], o.exp_addr, o.exp_be, o.exp_wdata} ||
            wb_control !== 8'h00 || mem_fault !== 1'b0) unstable++;
      end
      dmem_ack = 1'b1; dmem_rdata = RDATA;
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      total++;
      if (wb_memdata !== o.exp_mem || wb_control !== o.exp_ctrl) begin
        bad++;
        $display("FAIL mem_result@%h: got mem=%h ctrl=%h, required mem=%h ctrl=%h",
                 o.addr, wb_memdata, wb_control, o.exp_mem, o.exp_ctrl);
      end
      total++;
      if (dmem_req !== 1'b0 || mem_fault !== 1'b0 || mem_stall !== 1'b0 || ex_ready !== 1'b1) begin
        bad++;
        $display("FAIL mem_done@%h: got req=%b fault=%b stall=%b ready=%b, required 0 0 0 1",
                 o.addr, dmem_req, mem_fault, mem_stall, ex_ready);
      end
      total++;
      if (stall != o.delay + 1 || unstable != 0) begin
        bad++;
        $display("FAIL mem_stall@%h: got stall=%0d unstable=%0d, required stall=%0d unstable=0",
                 o.addr, stall, unstable, o.delay + 1);
      end
    end
  endtask

  task automatic test_timeout;
    int   req_cycles;
    int   early_fault;
    logic fault_at_drop;
    logic [7:0] ctrl_at_drop;
    logic ready_at_drop;
    bit   done;
    req_cycles = 0; early_fault = 0; done = 1'b0;
    fault_at_drop = 1'b0; ctrl_at_drop = 8'hFF; ready_at_drop = 1'b0;
    drive_entry(32'h400, 32'h0, 3'b010, 8'h28, 5'd9);
    for (int i = 0; i < 40 && !done; i++) begin
      if (dmem_req === 1'b1) begin
        req_cycles++;
        if (mem_fault !== 1'b0) early_fault++;
        @(posedge clk); #1;
      end else begin
        done          = 1'b1;
        fault_at_drop = mem_fault;
        ctrl_at_drop  = wb_control;
        ready_at_drop = ex_ready;
      end
    end
    total++;
    if (req_cycles != 15 || early_fault != 0) begin
      bad++;
      $display("FAIL timeout_len: got req_cycles=%0d early_fault=%0d, required 15 0", req_cycles, early_fault);
    end
    total++;
    if (fault_at_drop !== 1'b1 || ctrl_at_drop !== 8'h00 || ready_at_drop !== 1'b1) begin
      bad++;
      $display("FAIL timeout_fault: got fault=%b ctrl=%h ready=%b, required 1 00 1",
               fault_at_drop, ctrl_at_drop, ready_at_drop);
    end
    @(posedge clk); #1;
    total++;
    if (mem_fault !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse: got fault=%b one cycle later, required 0", mem_fault);
    end
  endtask

  task automatic test_reset_mid_access;
    drive_entry(32'h500, 32'h0, 3'b010, 8'h28, 5'd16);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, mem_fault, mem_stall} !== 72'h0 ||
        {wb_regdata, wb_memdata, wb_control, wb_reg_addr} !== 77'h0 || ex_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid: got req=%b addr=%h be=%b stall=%b ready=%b wbctrl=%h wbreg=%h, required all 0 and ready=1",
               dmem_req, dmem_addr, dmem_be, mem_stall, ex_ready, wb_control, wb_regdata);
    end
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    total++;
    if (wb_control !== 8'h00 || wb_memdata !== 32'h0 || dmem_req !== 1'b0 ||
        mem_stall !== 1'b0 || mem_fault !== 1'b0) begin
      bad++;
      $display("FAIL rst_stale_ack: got ctrl=%h mem=%h req=%b stall=%b fault=%b, required all 0",
               wb_control, wb_memdata, dmem_req, mem_stall, mem_fault);
    end
  endtask

  task automatic test_misalign;
`ifdef MEM_MISALIGN_CHECK_EN
    drive_entry(32'h101, 32'h0, 3'b010, 8'h28, 5'd17);
    total++;
    if (dmem_req !== 1'b0 || mem_fault !== 1'b1 || wb_control !== 8'h00 ||
        ex_ready !== 1'b1 || mem_stall !== 1'b0) begin
      bad++;
      $display("FAIL misalign_reject: got req=%b fault=%b ctrl=%h ready=%b stall=%b, required 0 1 00 1 0",
               dmem_req, mem_fault, wb_control, ex_ready, mem_stall);
    end
    @(posedge clk); #1;
    total++;
    if (mem_fault !== 1'b0 || dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL misalign_pulse: got fault=%b req=%b, required 0 0", mem_fault, dmem_req);
    end
`else
    // Without the check, the misaligned word goes out at the aligned address.
    drive_entry(32'h101, 32'h0, 3'b010, 8'h28, 5'd17);
    total++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || mem_fault !== 1'b0) begin
      bad++;
      $display("FAIL misalign_issue: got req=%b addr=%h fault=%b, required 1 00000100 0",
               dmem_req, dmem_addr, mem_fault);
    end
    exp_q.push_back('{32'h101, 32'h80FF_1234, 8'h28, 5'd17});
    dmem_ack = 1'b1; dmem_rdata = RDATA;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_alu_result = 32'h0; ex_store_data = 32'h0;
    ex_funct3 = 3'b000; ex_control = 8'h00; ex_rd = 5'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_back_to_back();
    test_mem_ops();
    test_timeout();
    test_reset_mid_access();
    test_misalign();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
- REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum cycles to wait for dmem_ack before abandoning an access.
- REQ-002 SHALL have port clk, input, 1: rising-edge clock.
- REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
- REQ-004 SHALL have port ex_valid, input, 1: EX/MEM entry valid.
- REQ-005 SHALL have port ex_ready, output, 1: stage accepts an entry this cycle.
- REQ-006 SHALL have port ex_alu_result, input, 32: memory address, or result for non-memory ops.
- REQ-007 SHALL have port ex_store_data, input, 32: rs2 data for stores.
- REQ-008 SHALL have port ex_funct3, input, 3: access size and sign.
- REQ-009 SHALL have port ex_control, input, 8: bit5 reg-write, bit3 mem-to-reg (load), bit1 mem-write; other bits pass through.
- REQ-010 SHALL have port ex_rd, input, 5: destination register.
- REQ-011 SHALL have ports dmem_req, dmem_we, output, 1 each: request strobe and write strobe.
- REQ-012 SHALL have port dmem_addr, output, 32: word-aligned address.
- REQ-013 SHALL have port dmem_wdata, output, 32: store data; port dmem_be, output, 4: byte enables.
- REQ-014 SHALL have port dmem_ack, input, 1: response valid; port dmem_rdata, input, 32: read word.
- REQ-015 SHALL have registered outputs wb_regdata (32), wb_memdata (32), wb_control (8) and wb_reg_addr (5), which feed the write-back stage.
- REQ-016 SHALL have port mem_stall, output, 1: high while an access is outstanding.
- REQ-017 SHALL have port mem_fault, output, 1: one-cycle pulse when an access is abandoned or rejected.

Function
- REQ-018 SHALL implement the FSM states IDLE and ACCESS, with ex_ready=1 only in IDLE.
- REQ-019 SHALL, in IDLE with ex_valid=1 and neither a load nor a store, register the entry to the wb_* outputs at the next edge (latency 1).
- REQ-020 SHALL, in IDLE with ex_valid=0, load wb_control with 0 (bubble) at the next edge.
- REQ-021 SHALL, in IDLE with ex_valid=1 and a load (ctrl[3]) or store (ctrl[1]), latch the entry, go to ACCESS and assert dmem_req from the next cycle.
- REQ-022 SHALL hold dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be stable in ACCESS until dmem_ack is seen.
- REQ-023 SHALL keep mem_stall=1 and wb_control=0 in ACCESS.
- REQ-024 SHALL, on dmem_ack in ACCESS, register the result to the wb_* outputs, drop dmem_req at the next edge and return to IDLE.
- REQ-025 SHALL, for a store completion, output wb_control with bit5 forced to 0.
- REQ-026 SHALL drive dmem_addr = {addr[31:2],2'b00}.
- REQ-027 SHALL extract load data from byte lane addr[1:0]: LB and LH sign-extend, LBU and LHU zero-extend, LW takes the full word; the result goes to wb_memdata.
- REQ-028 SHALL generate store enables as SB be=0001<<addr[1:0] with the byte replicated ×4, SH be=0011<<{addr[1],0} with the half replicated ×2, and SW be=1111.
- REQ-029 SHALL count wait cycles in ACCESS; at the count WAIT_MAX without ack it SHALL drop dmem_req, pulse mem_fault, output a bubble and return to IDLE.
- REQ-030 SHALL, when ack arrives in the same cycle the count hits WAIT_MAX, treat the ack as winning (normal completion, no fault).
- REQ-031 SHALL ignore dmem_ack while in IDLE.
- REQ-032 SHALL, on an undefined ex_funct3 (011, 110, 111) with a memory op, treat the access as LW/SW.

Reset
- REQ-033 SHALL, while rst_n=0 at an edge, force state=IDLE, counter=0, all wb_* outputs=0, dmem_req=dmem_we=0, dmem_addr=dmem_wdata=0, dmem_be=0 and mem_fault=0.
- REQ-034 SHALL, on reset during ACCESS, abandon the access and ignore any later ack for it.

Configuration
- REQ-035 SHALL, with MEM_MISALIGN_CHECK_EN defined, reject an LH/LHU/SH with addr[0]=1 or an LW/SW with addr[1:0]≠0 in IDLE: no dmem_req, a mem_fault pulse at the next edge, a bubble output, and the FSM stays in IDLE.
- REQ-036 SHALL, without MEM_MISALIGN_CHECK_EN, tie mem_fault from the alignment check to 0 and proceed with the access (halfword uses addr[1], word ignores addr[1:0]); timeout faults remain.

Structure
- REQ-037 SHALL place the funct3 constants, ex_control bit indices and FSM state typedef in shared package mem_stage_pkg.
- REQ-038 SHALL implement the lane extraction and extension in combinational sub-module load_align.

Verification
- REQ-039 SHALL cover: LB at addr 0x103, rdata 0x80FF_1234, ack after 2 cycles -> wb_memdata=0xFFFF_FF80, wb_control[5]=1, mem_stall high 3 cycles.
- REQ-040 SHALL cover: SH at addr 0x202, data 0x0000_ABCD -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_addr=0x200, wb_control[5]=0.
- REQ-041 SHALL cover: ALU op with ex_alu_result 0x55, rd 7 -> wb_regdata=0x55 and wb_reg_addr=7 the next cycle, with no dmem_req.
- REQ-042 SHALL cover: LW with no ack and WAIT_MAX=15 -> dmem_req dropped after 15 cycles, a one-cycle mem_fault pulse and a bubble.
- REQ-043 SHALL cover: rst_n low mid-ACCESS, then ack -> all outputs 0, state IDLE, and the ack ignored.
- REQ-044 SHALL cover: with MEM_MISALIGN_CHECK_EN defined, LW at 0x101 -> no dmem_req and a mem_fault pulse; without the macro -> access at 0x100.
